fft_stage_sequencer: RTL and testbench
======================================

// Module: fft_stage_sequencer
// PURPOSE
//  Control FSM for an in-place iterative radix-2 DIT FFT built on one shared butterfly unit and one N-entry sample RAM.
//  Writes input samples in bit-reversed order, issues every butterfly for every stage, then reads results out in natural order.
//  Per butterfly it drives the RAM pair addresses, the twiddle-table index (table of N/2 entries, W_N^k), and the stage number.
//  Sits between the sample source/sink and the butterfly datapath; contains no arithmetic on sample data.
// PARAMETERS
//  N           8  FFT size; power of two, N >= 4
//  BF_LATENCY  2  cycles from bf_issue to butterfly write-back in RAM; >= 1
//  Derived (localparam): LOG2N=$clog2(N), NUM_STAGES=LOG2N, NUM_BUTTERFLIES=N/2
// PORTS
//  clk             in   1                   clock, rising edge
//  reset           in   1                   synchronous, active-high
//  start           in   1                   begin one frame; sampled in IDLE only
//  busy            out  1                   high in every state except IDLE
//  done            out  1                   1-cycle pulse after the last output sample
//  in_valid        in   1                   input sample present
//  in_ready        out  1                   high in LOAD
//  load_we         out  1                   RAM write enable = in_valid & in_ready
//  load_addr       out  LOG2N               bit-reverse(load count)
//  bf_issue        out  1                   butterfly operands valid this cycle
//  bf_addr_a       out  LOG2N               top operand address
//  bf_addr_b       out  LOG2N               bottom operand address (= a + 2^s)
//  bf_twiddle_idx  out  LOG2N-1             index into N/2-entry twiddle table
//  bf_stage        out  $clog2(NUM_STAGES)  current stage s
//  out_ready       in   1                   sink may accept a sample
//  rd_en           out  1                   unload RAM read = UNLOAD & out_ready
//  rd_addr         out  LOG2N               natural-order read address
//  out_valid       out  1                   rd_en delayed 1 cycle (RAM read latency 1)
// BEHAVIOUR
//  Reset: state=IDLE, all counters 0; every output 0.
//  States: IDLE -> LOAD -> COMPUTE <-> DRAIN -> UNLOAD -> IDLE.
//  IDLE: start=1 -> LOAD next cycle; start in any other state is ignored.
//  LOAD: count k increments on each in_valid; load_addr = bitrev(k). After k=N-1 is written -> COMPUTE with s=0, b=0.
//  COMPUTE: 1 butterfly per cycle, bf_issue=1, b = 0..N/2-1, no stall.
//    grp = b >> s; pos = b & (2^s-1)
//    addr_a = grp*2^(s+1) + pos; addr_b = addr_a + 2^s
//    twiddle_idx = pos << (NUM_STAGES-1-s)
//    After b=N/2-1 -> DRAIN.
//  DRAIN: bf_issue=0 for exactly BF_LATENCY cycles (RAW hazard guard). Then s<NUM_STAGES-1: s++, b=0, -> COMPUTE; else -> UNLOAD.
//  UNLOAD: counter j advances only when out_ready=1; rd_addr=j, rd_en=out_ready. out_valid follows rd_en by 1 cycle.
//    After issuing j=N-1: stay in UNLOAD 1 extra cycle for the last out_valid, pulse done in that cycle, -> IDLE.
//  Back-to-back frames: start may be high the cycle after done; it is accepted from IDLE.
//  Cycle count (in_valid, out_ready held high): LOAD N, COMPUTE+DRAIN NUM_STAGES*(N/2+BF_LATENCY), UNLOAD N+1.
//  Counters wrap only via explicit reset to 0 on state exit; no free-running wrap.
//  Reset asserted mid-frame: return to IDLE next edge, frame discarded, no done pulse.
// TESTING (N=8, BF_LATENCY=2)
//  Load: start, in_valid=1 for 8 cycles -> load_addr 0,4,2,6,1,5,3,7; in_ready drops after the 8th cycle.
//  Load stall: in_valid toggles 1,0,1,... -> load_addr advances only on valid cycles; 8 writes, correct order.
//  Stage 0/1 -> (a,b,tw): s0 (0,1,0)(2,3,0)(4,5,0)(6,7,0); s1 (0,2,0)(1,3,2)(4,6,0)(5,7,2).
//  Stage 2 -> (0,4,0)(1,5,1)(2,6,2)(3,7,3); exactly 2 idle cycles between stages.
//  Unload with out_ready=1 -> rd_addr 0..7, 8 out_valid pulses, done 1 cycle after the last rd_en.
//  Unload with out_ready low for cycles 3-5 -> rd_addr holds, no extra valids.
//  Reset mid-COMPUTE -> next cycle busy=0, bf_issue=0, all outputs 0; a new start runs a full, correct frame.
//  start while busy -> ignored, sequence unchanged.

Source files
------------

// File: rtl/fft_stage_sequencer_if.sv
// Control/handshake bundle between the FFT stage sequencer and its source, sink and butterfly datapath.
// The slave modport is the sequencer; the master modport is whoever drives start and the stream handshakes.
interface fft_stage_sequencer_if #(
  parameter int N = 8
);
  localparam int LOG2N   = $clog2(N);
  localparam int STAGE_W = $clog2(LOG2N);

  logic               start_i;
  logic               busy_o;
  logic               done_o;
  logic               in_valid_i;
  logic               in_ready_o;
  logic               load_we_o;
  logic [LOG2N-1:0]   load_addr_o;
  logic               bf_issue_o;
  logic [LOG2N-1:0]   bf_addr_a_o;
  logic [LOG2N-1:0]   bf_addr_b_o;
  logic [LOG2N-2:0]   bf_twiddle_idx_o;
  logic [STAGE_W-1:0] bf_stage_o;
  logic               out_ready_i;
  logic               rd_en_o;
  logic [LOG2N-1:0]   rd_addr_o;
  logic               out_valid_o;

  modport master (
    output start_i, in_valid_i, out_ready_i,
    input  busy_o, done_o, in_ready_o, load_we_o, load_addr_o,
           bf_issue_o, bf_addr_a_o, bf_addr_b_o, bf_twiddle_idx_o, bf_stage_o,
           rd_en_o, rd_addr_o, out_valid_o
  );

  modport slave (
    input  start_i, in_valid_i, out_ready_i,
    output busy_o, done_o, in_ready_o, load_we_o, load_addr_o,
           bf_issue_o, bf_addr_a_o, bf_addr_b_o, bf_twiddle_idx_o, bf_stage_o,
           rd_en_o, rd_addr_o, out_valid_o
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Control FSM for an in-place radix-2 DIT FFT: bit-reversed load, one butterfly per cycle per stage
// with a write-back drain between stages, then natural-order unload. No sample arithmetic here.
module fft_stage_sequencer #(
  parameter int N          = 8,
  parameter int BF_LATENCY = 2
) (
  input logic                 clk,
  input logic                 reset,
  fft_stage_sequencer_if.slave bus
);
  localparam int LOG2N           = $clog2(N);
  localparam int NUM_STAGES      = LOG2N;
  localparam int NUM_BUTTERFLIES = N / 2;
  localparam int STAGE_W         = $clog2(NUM_STAGES);
  localparam int DRAIN_W         = $clog2(BF_LATENCY + 1);
  localparam int TW_W            = LOG2N - 1;

  typedef logic [LOG2N-1:0]   addr_t;
  typedef logic [STAGE_W-1:0] stage_t;
  typedef logic [DRAIN_W-1:0] drain_t;

  localparam addr_t  ONE_ADDR    = addr_t'(1);
  localparam addr_t  LAST_SAMPLE = addr_t'(N - 1);
  localparam addr_t  LAST_BF     = addr_t'(NUM_BUTTERFLIES - 1);
  localparam stage_t ONE_STAGE   = stage_t'(1);
  localparam stage_t LAST_STAGE  = stage_t'(NUM_STAGES - 1);
  localparam drain_t ONE_DRAIN   = drain_t'(1);
  localparam drain_t LAST_DRAIN  = drain_t'(BF_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, UNLOAD} state_t;

  state_t state_q, state_d;
  addr_t  cnt_q, cnt_d;
  stage_t stage_q, stage_d;
  drain_t drain_q, drain_d;
  logic   last_q, last_d;

  logic   busy_q, inReady_q, bfIssue_q, rdArm_q, done_q, outValid_q;
  addr_t  loadAddr_q, bfAddrA_q, bfAddrB_q, rdAddr_q;
  logic [TW_W-1:0] bfTw_q;
  stage_t bfStage_q;

  function automatic addr_t bitRev(input addr_t v);
    addr_t r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  function automatic addr_t posMask(input stage_t s);
    return (ONE_ADDR << s) - ONE_ADDR;
  endfunction

  // Inserting a zero bit at position s of b splits it into group and position: addr_a = grp*2^(s+1) + pos.
  function automatic addr_t addrA(input addr_t b, input stage_t s);
    return ((b & ~posMask(s)) << 1) | (b & posMask(s));
  endfunction

  function automatic logic [TW_W-1:0] twIdx(input addr_t b, input stage_t s);
    addr_t full;
    full = (b & posMask(s)) << (LAST_STAGE - s);
    return full[TW_W-1:0];
  endfunction

  // Next-state logic: one shared counter serves as load count, butterfly index and unload index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    drain_d = drain_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (bus.in_valid_i) begin
          if (cnt_q == LAST_SAMPLE) begin
            state_d = COMPUTE;
            cnt_d   = '0;
            stage_d = '0;
          end else begin
            cnt_d = cnt_q + ONE_ADDR;
          end
        end
      end
      COMPUTE: begin
        if (cnt_q == LAST_BF) begin
          state_d = DRAIN;
          cnt_d   = '0;
          drain_d = '0;
        end else begin
          cnt_d = cnt_q + ONE_ADDR;
        end
      end
      DRAIN: begin
        if (drain_q == LAST_DRAIN) begin
          drain_d = '0;
          if (stage_q == LAST_STAGE) begin
            state_d = UNLOAD;
            stage_d = '0;
          end else begin
            state_d = COMPUTE;
            stage_d = stage_q + ONE_STAGE;
          end
        end else begin
          drain_d = drain_q + ONE_DRAIN;
        end
      end
      UNLOAD: begin
        // last_q marks the extra cycle that carries the final out_valid and the done pulse.
        if (last_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          last_d  = 1'b0;
        end else if (bus.out_ready_i) begin
          if (cnt_q == LAST_SAMPLE) begin
            last_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE_ADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; outputs are computed from next-state values so they align with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      stage_q    <= '0;
      drain_q    <= '0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      inReady_q  <= 1'b0;
      loadAddr_q <= '0;
      bfIssue_q  <= 1'b0;
      bfAddrA_q  <= '0;
      bfAddrB_q  <= '0;
      bfTw_q     <= '0;
      bfStage_q  <= '0;
      rdArm_q    <= 1'b0;
      rdAddr_q   <= '0;
      done_q     <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stage_q    <= stage_d;
      drain_q    <= drain_d;
      last_q     <= last_d;
      busy_q     <= (state_d != IDLE);
      inReady_q  <= (state_d == LOAD);
      loadAddr_q <= (state_d == LOAD) ? bitRev(cnt_d) : '0;
      bfIssue_q  <= (state_d == COMPUTE);
      bfAddrA_q  <= (state_d == COMPUTE) ? addrA(cnt_d, stage_d) : '0;
      bfAddrB_q  <= (state_d == COMPUTE) ? (addrA(cnt_d, stage_d) | (ONE_ADDR << stage_d)) : '0;
      bfTw_q     <= (state_d == COMPUTE) ? twIdx(cnt_d, stage_d) : '0;
      bfStage_q  <= (state_d == COMPUTE || state_d == DRAIN) ? stage_d : '0;
      rdArm_q    <= (state_d == UNLOAD) && !last_d;
      rdAddr_q   <= (state_d == UNLOAD) ? cnt_d : '0;
      done_q     <= (state_d == UNLOAD) && last_d;
      outValid_q <= rdArm_q & bus.out_ready_i;
    end
  end

  assign bus.busy_o           = busy_q;
  assign bus.done_o           = done_q;
  assign bus.in_ready_o       = inReady_q;
  assign bus.load_we_o        = inReady_q & bus.in_valid_i;
  assign bus.load_addr_o      = loadAddr_q;
  assign bus.bf_issue_o       = bfIssue_q;
  assign bus.bf_addr_a_o      = bfAddrA_q;
  assign bus.bf_addr_b_o      = bfAddrB_q;
  assign bus.bf_twiddle_idx_o = bfTw_q;
  assign bus.bf_stage_o       = bfStage_q;
  assign bus.rd_en_o          = rdArm_q & bus.out_ready_i;
  assign bus.rd_addr_o        = rdAddr_q;
  assign bus.out_valid_o      = outValid_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer at N=8, BF_LATENCY=2: a cycle-vector table for a stalled frame
// plus hand-written clean frames, back-to-back start and reset in the middle of the compute phase.
module tb_fft_stage_sequencer;
  logic clk = 1'b0;
  logic reset;

  fft_stage_sequencer_if #(.N(8)) bus();

  fft_stage_sequencer #(.N(8), .BF_LATENCY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit start; bit inV; bit outR;
    bit busy; bit inRdy; bit we; int la;
    bit iss; int a; int b; int tw; int st;
    bit unl; bit rdEn; int ra; bit ov; bit done;
  } vec_t;

  typedef struct { int a; int b; int tw; } bf_t;

  vec_t vecQ[$];
  bf_t  bfTab[12];
  int   loadOrder[8];
  int   errors = 0;
  int   checks = 0;

  function automatic void addVec(bit start, bit inV, bit outR, bit busy, bit inRdy, bit we, int la,
                                 bit iss, int a, int b, int tw, int st,
                                 bit unl, bit rdEn, int ra, bit ov, bit done);
    vec_t v;
    v.start = start; v.inV = inV; v.outR = outR;
    v.busy = busy; v.inRdy = inRdy; v.we = we; v.la = la;
    v.iss = iss; v.a = a; v.b = b; v.tw = tw; v.st = st;
    v.unl = unl; v.rdEn = rdEn; v.ra = ra; v.ov = ov; v.done = done;
    vecQ.push_back(v);
  endfunction

  task automatic applyStimulus(input bit s, input bit v, input bit r, input bit rst);
    @(posedge clk);
    #1;
    reset          = rst;
    bus.start_i    = s;
    bus.in_valid_i = v;
    bus.out_ready_i = r;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"}, int'(bus.busy_o), 0);
    checkOutput({tag, " done"}, int'(bus.done_o), 0);
    checkOutput({tag, " in_ready"}, int'(bus.in_ready_o), 0);
    checkOutput({tag, " load_we"}, int'(bus.load_we_o), 0);
    checkOutput({tag, " load_addr"}, int'(bus.load_addr_o), 0);
    checkOutput({tag, " bf_issue"}, int'(bus.bf_issue_o), 0);
    checkOutput({tag, " bf_addr_a"}, int'(bus.bf_addr_a_o), 0);
    checkOutput({tag, " bf_addr_b"}, int'(bus.bf_addr_b_o), 0);
    checkOutput({tag, " bf_twiddle"}, int'(bus.bf_twiddle_idx_o), 0);
    checkOutput({tag, " bf_stage"}, int'(bus.bf_stage_o), 0);
    checkOutput({tag, " rd_en"}, int'(bus.rd_en_o), 0);
    checkOutput({tag, " rd_addr"}, int'(bus.rd_addr_o), 0);
    checkOutput({tag, " out_valid"}, int'(bus.out_valid_o), 0);
  endtask

  task automatic cleanFrame(input bit doStart, input string tag);
    if (doStart) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput({tag, " idle busy"}, int'(bus.busy_o), 0);
    end
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("%s load%0d in_ready", tag, k), int'(bus.in_ready_o), 1);
      checkOutput($sformatf("%s load%0d we", tag, k), int'(bus.load_we_o), 1);
      checkOutput($sformatf("%s load%0d addr", tag, k), int'(bus.load_addr_o), loadOrder[k]);
    end
    for (int s = 0; s < 3; s++) begin
      for (int b = 0; b < 4; b++) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput($sformatf("%s s%0d b%0d issue", tag, s, b), int'(bus.bf_issue_o), 1);
        checkOutput($sformatf("%s s%0d b%0d a", tag, s, b), int'(bus.bf_addr_a_o), bfTab[s*4+b].a);
        checkOutput($sformatf("%s s%0d b%0d b", tag, s, b), int'(bus.bf_addr_b_o), bfTab[s*4+b].b);
        checkOutput($sformatf("%s s%0d b%0d tw", tag, s, b), int'(bus.bf_twiddle_idx_o), bfTab[s*4+b].tw);
        checkOutput($sformatf("%s s%0d b%0d stage", tag, s, b), int'(bus.bf_stage_o), s);
        checkOutput($sformatf("%s s%0d b%0d in_ready", tag, s, b), int'(bus.in_ready_o), 0);
      end
      for (int d = 0; d < 2; d++) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput($sformatf("%s s%0d drain%0d issue", tag, s, d), int'(bus.bf_issue_o), 0);
        checkOutput($sformatf("%s s%0d drain%0d busy", tag, s, d), int'(bus.busy_o), 1);
      end
    end
    for (int j = 0; j < 8; j++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("%s unload%0d rd_en", tag, j), int'(bus.rd_en_o), 1);
      checkOutput($sformatf("%s unload%0d rd_addr", tag, j), int'(bus.rd_addr_o), j);
      checkOutput($sformatf("%s unload%0d out_valid", tag, j), int'(bus.out_valid_o), (j > 0) ? 1 : 0);
      checkOutput($sformatf("%s unload%0d done", tag, j), int'(bus.done_o), 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput({tag, " tail rd_en"}, int'(bus.rd_en_o), 0);
    checkOutput({tag, " tail out_valid"}, int'(bus.out_valid_o), 1);
    checkOutput({tag, " tail done"}, int'(bus.done_o), 1);
    checkOutput({tag, " tail busy"}, int'(bus.busy_o), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, " after busy"}, int'(bus.busy_o), 0);
    checkOutput({tag, " after done"}, int'(bus.done_o), 0);
    checkOutput({tag, " after out_valid"}, int'(bus.out_valid_o), 0);
  endtask

  initial begin
    int laSeq[15];
    int raSeq[11];
    bit rdySeq[11];
    bit ovSeq[11];

    loadOrder = '{0, 4, 2, 6, 1, 5, 3, 7};
    bfTab = '{'{0, 1, 0}, '{2, 3, 0}, '{4, 5, 0}, '{6, 7, 0},
              '{0, 2, 0}, '{1, 3, 2}, '{4, 6, 0}, '{5, 7, 2},
              '{0, 4, 0}, '{1, 5, 1}, '{2, 6, 2}, '{3, 7, 3}};

    // Stalled frame: in_valid toggles during load, start held high in stage 0, out_ready low for unload cycles 3-5.
    laSeq  = '{0, 4, 4, 2, 2, 6, 6, 1, 1, 5, 5, 3, 3, 7, 7};
    raSeq  = '{0, 1, 2, 3, 3, 3, 3, 4, 5, 6, 7};
    rdySeq = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    ovSeq  = '{0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
    addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++)
      addVec(0, (i % 2 == 0), 0, 1, 1, (i % 2 == 0), laSeq[i], 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int s = 0; s < 3; s++) begin
      for (int b = 0; b < 4; b++)
        addVec((s == 0), (s == 0), 0, 1, 0, 0, 0, 1, bfTab[s*4+b].a, bfTab[s*4+b].b, bfTab[s*4+b].tw, s,
               0, 0, 0, 0, 0);
      addVec(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      addVec(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    for (int u = 0; u < 11; u++)
      addVec(0, 0, rdySeq[u], 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, rdySeq[u], raSeq[u], ovSeq[u], 0);
    addVec(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    reset = 1'b1;
    bus.start_i = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b0;

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkAllZero("reset");

    for (int i = 0; i < vecQ.size(); i++) begin
      applyStimulus(vecQ[i].start, vecQ[i].inV, vecQ[i].outR, 1'b0);
      checkOutput($sformatf("row%0d busy", i), int'(bus.busy_o), int'(vecQ[i].busy));
      checkOutput($sformatf("row%0d in_ready", i), int'(bus.in_ready_o), int'(vecQ[i].inRdy));
      checkOutput($sformatf("row%0d load_we", i), int'(bus.load_we_o), int'(vecQ[i].we));
      checkOutput($sformatf("row%0d bf_issue", i), int'(bus.bf_issue_o), int'(vecQ[i].iss));
      checkOutput($sformatf("row%0d rd_en", i), int'(bus.rd_en_o), int'(vecQ[i].rdEn));
      checkOutput($sformatf("row%0d out_valid", i), int'(bus.out_valid_o), int'(vecQ[i].ov));
      checkOutput($sformatf("row%0d done", i), int'(bus.done_o), int'(vecQ[i].done));
      if (vecQ[i].inRdy)
        checkOutput($sformatf("row%0d load_addr", i), int'(bus.load_addr_o), vecQ[i].la);
      if (vecQ[i].iss) begin
        checkOutput($sformatf("row%0d bf_addr_a", i), int'(bus.bf_addr_a_o), vecQ[i].a);
        checkOutput($sformatf("row%0d bf_addr_b", i), int'(bus.bf_addr_b_o), vecQ[i].b);
        checkOutput($sformatf("row%0d bf_twiddle", i), int'(bus.bf_twiddle_idx_o), vecQ[i].tw);
        checkOutput($sformatf("row%0d bf_stage", i), int'(bus.bf_stage_o), vecQ[i].st);
      end
      if (vecQ[i].unl)
        checkOutput($sformatf("row%0d rd_addr", i), int'(bus.rd_addr_o), vecQ[i].ra);
    end

    // Last table row raised start the cycle after done, so this frame is already under way.
    cleanFrame(1'b0, "b2b");

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst pre issue", int'(bus.bf_issue_o), 1);
    checkOutput("midrst pre a", int'(bus.bf_addr_a_o), 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("midrst hold a", int'(bus.bf_addr_a_o), 6);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkAllZero("midrst");
    cleanFrame(1'b1, "postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
